// File: rtl/score_pulse_gen.sv
// -----------------------------------------------------------------------------
// score_pulse_gen
//
// Upstream scoring stage for the Flappy Bird score display. Tracks the game
// state (IDLE / PLAY / OVER), watches the leading pipe column and emits one
// single-cycle upCount pulse every time a pipe clears the bird's column while
// the bird is alive. It also keeps a saturating binary point total and
// issues a one-cycle clear_scores pulse when a finished game is dismissed,
// so the downstream decimal digit counters restart at zero.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous active-low reset (0 = in reset)
//   start         in   start button level (debounced, synchronized)
//   crash         in   collision level, sampled every cycle
//   pipe_shift    in   one-cycle strobe: pipes move one column left
//   pipe_col      in   leading pipe column before the shift (valid with strobe)
//   upCount       out  one-cycle point pulse to the least-significant digit
//   clear_scores  out  one-cycle pulse: downstream counters go to zero
//   points        out  saturating point total, 0..MAX_POINTS
//   playing       out  high while in PLAY
//   game_over     out  high while in OVER
//   dbg_state_o   out  raw FSM state (0 IDLE, 1 PLAY, 2 OVER) for checkers
//
// Interface semantics: pipe_shift is a strobe with no back-pressure; pipe_col
// is only looked at on a cycle where pipe_shift=1 and the FSM is in PLAY.
// Every output is a flop, so each response shows up one cycle after the edge
// that sampled the inputs.
// -----------------------------------------------------------------------------
module score_pulse_gen #(
  parameter int               COL_W      = 4,
  parameter logic [COL_W-1:0] BIRD_COL   = COL_W'(3),
  parameter int               MAX_POINTS = 99
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             crash,
  input  logic             pipe_shift,
  input  logic [COL_W-1:0] pipe_col,
  output logic             upCount,
  output logic             clear_scores,
  output logic [6:0]       points,
  output logic             playing,
  output logic             game_over,
  output logic [1:0]       dbg_state_o
);

  localparam logic [6:0] MAX_PTS = 7'(MAX_POINTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] points_q, points_d;
  logic       armed_q, armed_d;
  logic       upcount_q, upcount_d;
  logic       clear_q, clear_d;
  logic       playing_q, game_over_q;

  logic at_bird;
  assign at_bird = (pipe_col == BIRD_COL);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; crash has top priority inside PLAY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PLAY;
      ST_PLAY: if (crash) state_d = ST_OVER;
      ST_OVER: if (start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    points_d  = points_q;
    armed_d   = armed_q;
    upcount_d = 1'b0;
    clear_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          points_d = '0;
          armed_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (crash) begin
          // Dying on the same cycle as a pass earns nothing.
          points_d = points_q;
        end else if (pipe_shift) begin
          if (at_bird) begin
            // A pipe sitting at the bird column for several shifts (stall or
            // wrap) must score only once, so disarm even when saturated.
            armed_d = 1'b0;
            if (armed_q && (points_q < MAX_PTS)) begin
              upcount_d = 1'b1;
              points_d  = points_q + 7'd1;
            end
          end else begin
            armed_d = 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          clear_d  = 1'b1;
          points_d = '0;
        end
      end
      default: begin
        points_d = '0;
        armed_d  = 1'b1;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      points_q    <= '0;
      armed_q     <= 1'b1;
      upcount_q   <= 1'b0;
      clear_q     <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      points_q    <= points_d;
      armed_q     <= armed_d;
      upcount_q   <= upcount_d;
      clear_q     <= clear_d;
      playing_q   <= (state_d == ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign upCount      = upcount_q;
  assign clear_scores = clear_q;
  assign points       = points_q;
  assign playing      = playing_q;
  assign game_over    = game_over_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_score_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_score_pulse_gen
//
// Drives score_pulse_gen one cycle at a time. A behavioural game model
// predicts {upCount, clear_scores, points, playing, game_over} for the cycle
// after each drive; the prediction goes into exp_q and is popped and
// compared once the DUT has clocked. Extra checks count upCount pulses per
// scenario and probe the asynchronous reset between clock edges.
// -----------------------------------------------------------------------------
module tb_score_pulse_gen;

  localparam int W = 11;  // {up, clr, points[6:0], playing, over}

  logic       clk;
  logic       reset;
  logic       start;
  logic       crash;
  logic       pipe_shift;
  logic [3:0] pipe_col;
  logic       upCount;
  logic       clear_scores;
  logic [6:0] points;
  logic       playing;
  logic       game_over;
  logic [1:0] dbg_state;

  score_pulse_gen #(
    .COL_W     (4),
    .BIRD_COL  (4'd3),
    .MAX_POINTS(99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .crash       (crash),
    .pipe_shift  (pipe_shift),
    .pipe_col    (pipe_col),
    .upCount     (upCount),
    .clear_scores(clear_scores),
    .points      (points),
    .playing     (playing),
    .game_over   (game_over),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int up_seen = 0;

  // Reference game model
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
  int m_state  = M_IDLE;
  int m_points = 0;
  bit m_armed  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_points = 0;
    m_armed  = 1'b1;
  endtask

  // Advance the model by one sampled cycle and return the predicted outputs.
  function automatic logic [W-1:0] model_step(input bit st, input bit cr,
                                              input bit sh, input int col);
    bit up = 1'b0;
    bit clr = 1'b0;
    if (m_state == M_IDLE) begin
      if (st) begin
        m_state  = M_PLAY;
        m_points = 0;
        m_armed  = 1'b1;
      end
    end else if (m_state == M_PLAY) begin
      if (cr) begin
        m_state = M_OVER;
      end else if (sh && col == 3) begin
        if (m_armed && m_points < 99) begin
          up = 1'b1;
          m_points = m_points + 1;
        end
        m_armed = 1'b0;
      end else if (sh) begin
        m_armed = 1'b1;
      end
    end else begin
      if (st) begin
        m_state  = M_IDLE;
        clr      = 1'b1;
        m_points = 0;
      end
    end
    return {up, clr, 7'(m_points), m_state == M_PLAY, m_state == M_OVER};
  endfunction

  // Compare the DUT outputs against the oldest queued prediction.
  task automatic score_pop(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_up"},      upCount,      e[10]);
    check({tag, "_clr"},     clear_scores, e[9]);
    check({tag, "_points"},  points,       e[8:2]);
    check({tag, "_playing"}, playing,      e[1]);
    check({tag, "_over"},    game_over,    e[0]);
    check({tag, "_excl"},    upCount & clear_scores, 0);
    if (upCount) up_seen++;
  endtask

  // Drive one cycle of inputs, predict, then check after the edge.
  task automatic drive(input string tag, input bit st, input bit cr,
                       input bit sh, input int col);
    @(negedge clk);
    start      = st;
    crash      = cr;
    pipe_shift = sh;
    pipe_col   = 4'(col);
    exp_q.push_back(model_step(st, cr, sh, col));
    @(posedge clk);
    #1;
    score_pop(tag);
  endtask

  task automatic idle_cycle(input string tag);
    drive(tag, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_up"},      upCount,      0);
    check({tag, "_clr"},     clear_scores, 0);
    check({tag, "_points"},  points,       0);
    check({tag, "_playing"}, playing,      0);
    check({tag, "_over"},    game_over,    0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int cols[4];
    reset      = 1'b0;
    start      = 1'b0;
    crash      = 1'b0;
    pipe_shift = 1'b0;
    pipe_col   = '0;
    model_reset();

    // 1. Reset held two cycles, then released.
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    reset = 1'b1;
    idle_cycle("post_reset");
    // Pipe shifts in IDLE are ignored.
    drive("idle_shift", 1'b0, 1'b0, 1'b1, 3);

    // 2. Start, then the pipe walks 5,4,3,2: one point on the col=3 shift.
    drive("start", 1'b1, 1'b0, 1'b0, 0);
    base = up_seen;
    cols = '{5, 4, 3, 2};
    foreach (cols[i]) drive("walk", 1'b0, 1'b0, 1'b1, cols[i]);
    idle_cycle("walk_tail");
    check("walk_pulses", up_seen - base, 1);
    check("walk_points", points, 1);

    // Finish this game and begin a fresh one.
    drive("crash", 1'b0, 1'b1, 1'b0, 0);
    drive("dismiss", 1'b1, 1'b0, 1'b0, 0);
    drive("restart", 1'b1, 1'b0, 1'b0, 0);

    // 3. Stall at col 3 (x3), move to 2, back to 3: two points only.
    base = up_seen;
    repeat (3) drive("stall", 1'b0, 1'b0, 1'b1, 3);
    drive("rearm", 1'b0, 1'b0, 1'b1, 2);
    drive("again", 1'b0, 1'b0, 1'b1, 3);
    check("stall_pulses", up_seen - base, 2);
    check("stall_points", points, 2);

    // Random stretch in PLAY without crashes.
    repeat (20) drive("rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 5)));
    drive("rearm2", 1'b0, 1'b0, 1'b1, 2);

    // 4. Qualifying pass together with a crash: no point, then OVER.
    base = up_seen;
    drive("crash_pass", 1'b0, 1'b1, 1'b1, 3);
    check("crash_pass_pulses", up_seen - base, 0);
    check("crash_over", game_over, 1);
    drive("over_shift", 1'b0, 1'b0, 1'b1, 3);
    drive("clear", 1'b1, 1'b0, 1'b0, 0);
    check("clear_pulse", clear_scores, 1);
    idle_cycle("after_clear");
    check("clear_one_cycle", clear_scores, 0);

    // 5. 105 qualifying passes: saturate at 99.
    drive("start_sat", 1'b1, 1'b0, 1'b0, 0);
    base = up_seen;
    repeat (105) begin
      drive("sat3", 1'b0, 1'b0, 1'b1, 3);
      drive("sat2", 1'b0, 1'b0, 1'b1, 2);
    end
    check("sat_pulses", up_seen - base, 99);
    check("sat_points", points, 99);

    // 6. Async reset landing on the edge of a qualifying pass.
    drive("reset_game", 1'b0, 1'b1, 1'b0, 0);
    drive("reset_dismiss", 1'b1, 1'b0, 1'b0, 0);
    drive("reset_start", 1'b1, 1'b0, 1'b0, 0);
    drive("reset_arm", 1'b0, 1'b0, 1'b1, 2);
    @(negedge clk);
    start      = 1'b0;
    crash      = 1'b0;
    pipe_shift = 1'b1;
    pipe_col   = 4'd3;
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_state", dbg_state, 0);
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    model_reset();
    @(negedge clk);
    reset      = 1'b1;
    pipe_shift = 1'b0;
    idle_cycle("rst_release");

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_pulse_gen.md
Name: score_pulse_gen

Overview:
- Upstream scoring stage for the Flappy Bird score display.
- Tracks game state (idle / playing / over) and watches the leading pipe column.
- Emits exactly one single-cycle upCount pulse each time a pipe clears the bird's column while the bird is alive. This pulse drives the least-significant decimal digit counter of the score chain.
- Also keeps a saturating binary point total, and issues a one-cycle clear pulse so the downstream digit counters restart at zero for a new game.

Parameters:
- COL_W, 4, width of the pipe column index (16-column LED field).
- BIRD_COL, 4'd3, fixed column occupied by the bird.
- MAX_POINTS, 99, point total at which scoring saturates, so a two-digit display never wraps.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- start  input  1  level from the start button, already debounced and synchronized.
- crash  input  1  collision flag from collision logic; a level, sampled each cycle.
- pipe_shift  input  1  one-cycle strobe; pipes shift one column left this cycle.
- pipe_col  input  COL_W  column of the leading pipe before the shift, valid when pipe_shift=1.
- upCount  output  1  one-cycle point pulse to the digit counter.
- clear_scores  output  1  one-cycle pulse; downstream counters reset to zero.
- points  output  7  saturating point total, 0..MAX_POINTS.
- playing  output  1  high in the PLAY state.
- game_over  output  1  high in the OVER state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, upCount=0, clear_scores=0, points=0, armed=1.
  - playing=0, game_over=0.
- All outputs are registered. Every response appears on the cycle after the sampling edge (latency 1).
- States: IDLE, PLAY, OVER.
- IDLE:
  - start=1 → PLAY; points←0, armed←1.
  - Otherwise stay in IDLE.
  - upCount is never asserted in IDLE.
- PLAY, priority order each cycle:
  1. crash=1 → OVER. No point is awarded this cycle, even if a pass qualifies on the same cycle.
  2. pipe_shift=1, pipe_col==BIRD_COL, armed=1, points<MAX_POINTS → upCount=1 for exactly one cycle, points←points+1, armed←0.
  3. pipe_shift=1, pipe_col!=BIRD_COL → armed←1.
  - start is ignored while in PLAY.
- Arming rule: at most one point per pipe. A pipe sampled at BIRD_COL on repeated shifts (stall or wrap) scores once only. Scoring re-arms only after a shift sampled at a different column.
- Saturation:
  - At points==MAX_POINTS, further qualifying passes produce no upCount and points hold.
  - armed still clears on such a pass.
- OVER:
  - game_over=1; points and the downstream display are held.
  - start=1 → IDLE and clear_scores=1 for one cycle; points←0 on the same edge.
- pipe_shift outside PLAY: ignored. armed is set to 1 on every entry to PLAY.
- upCount and clear_scores are never high on the same cycle.
- Reset mid-game: immediate return to IDLE, all outputs 0. Any in-flight upCount is dropped.
- points width: 7 bits, unsigned; the increment never exceeds MAX_POINTS.

Test Plan:
1. Reset low for 2 cycles, then release → state IDLE; upCount=0, clear_scores=0, points=0, playing=0, game_over=0.
2. start=1 for one cycle, then pipe_shift pulses with pipe_col=5,4,3,2 → playing=1. Exactly one upCount, on the cycle after the col=3 shift; points=1.
3. In PLAY, pipe_shift with pipe_col=3 three times in a row, then col=2, then col=3 → two upCount pulses total; points goes 0→1 and 1→2 only.
4. In PLAY, pipe_shift with col=3 together with crash=1 on the same cycle → upCount stays 0, points unchanged, next cycle game_over=1. A later start=1 → clear_scores high for 1 cycle, points=0, state IDLE.
5. Drive 105 qualifying passes (col 3 then col 2, repeated) → 99 upCount pulses; points saturates at 99 with no further pulses.
6. Assert reset on the same edge as a qualifying pass → upCount stays 0, points=0, state IDLE asynchronously without waiting for a clock edge.
